// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared types and default sizes for the byte FIFO controller
package fifo_ctrl_pkg;

   // Read-side sequencer states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } rd_state_t;

   localparam int DEF_DEPTH     = 32768;
   localparam int DEF_LW        = 15;
   localparam int DEF_AF_THRESH = 32000;

endpackage

// File: rtl/fifo_ctrl_rr_arb2.sv
// rtl/fifo_ctrl_rr_arb2.sv - two-way round-robin arbiter with eligibility inputs
module rr_arb2 (
   input  logic i_elig0,
   input  logic i_elig1,
   input  logic i_pri1,
   output logic o_gnt0,
   output logic o_gnt1,
   output logic o_pri1_nxt
);

   // Pick a winner; on contention the requester not served last wins, and priority flips after every grant
   always_comb begin
      o_gnt0     = 1'b0;
      o_gnt1     = 1'b0;
      o_pri1_nxt = i_pri1;
      if (i_elig0 && i_elig1) begin
         if (i_pri1) begin
            o_gnt1     = 1'b1;
            o_pri1_nxt = 1'b0;
         end else begin
            o_gnt0     = 1'b1;
            o_pri1_nxt = 1'b1;
         end
      end else if (i_elig0) begin
         o_gnt0     = 1'b1;
         o_pri1_nxt = 1'b1;
      end else if (i_elig1) begin
         o_gnt1     = 1'b1;
         o_pri1_nxt = 1'b0;
      end
   end

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - write arbiter, read sequencer and occupancy tracker for the shared byte FIFO (option: FIFO_CTRL_WATERMARK_EN)
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int LW        = DEF_LW,
   parameter int AF_THRESH = DEF_AF_THRESH
) (
   input  logic          clock,
   input  logic          sclr,
   input  logic          flush,
   input  logic          wr0_req,
   input  logic [7:0]    wr0_data,
   output logic          wr0_ack,
   input  logic          wr1_req,
   input  logic [7:0]    wr1_data,
   output logic          wr1_ack,
   output logic          rd_valid,
   output logic [7:0]    rd_data,
   input  logic          rd_ready,
   output logic [7:0]    fifo_data,
   output logic          fifo_wrreq,
   output logic          fifo_rdreq,
   output logic          fifo_sclr,
   input  logic [7:0]    fifo_q,
   input  logic          fifo_empty,
   input  logic          fifo_full,
   output logic [LW-1:0] level,
`ifdef FIFO_CTRL_WATERMARK_EN
   output logic          almost_full,
`endif
   output logic          err
);

   // One extra bit so the count can represent a completely full FIFO when DEPTH == 2**LW
   localparam int CW = LW + 1;
   localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
   localparam logic [CW-1:0] C_LVL_MAX = CW'((2 ** LW) - 1);

   logic [CW-1:0] r_level;
   logic [CW-1:0] w_level_nxt;
   logic          r_ack0, r_ack1, r_wrreq, r_fsclr, r_pri1;
   logic [7:0]    r_fdata;
   rd_state_t     r_state;
   logic          r_rdreq, r_rd_valid;
   logic [7:0]    r_rd_data;
   logic          r_err;
   logic          w_room, w_elig0, w_elig1;
   logic          w_gnt0, w_gnt1, w_grant, w_pri1_nxt;

   // A read hitting the FIFO this cycle frees a slot before the granted write lands next cycle
   assign w_room  = (r_level < C_DEPTH) || r_rdreq;
   assign w_elig0 = wr0_req && !r_ack0 && w_room && !flush;
`ifdef FIFO_CTRL_WATERMARK_EN
   logic r_af;
   assign w_elig1 = wr1_req && !r_ack1 && w_room && !flush && !r_af;
`else
   assign w_elig1 = wr1_req && !r_ack1 && w_room && !flush;
`endif

   rr_arb2 u_arb (
      .i_elig0    (w_elig0),
      .i_elig1    (w_elig1),
      .i_pri1     (r_pri1),
      .o_gnt0     (w_gnt0),
      .o_gnt1     (w_gnt1),
      .o_pri1_nxt (w_pri1_nxt)
   );

   assign w_grant = w_gnt0 || w_gnt1;

   // Occupancy moves +1 per granted write and -1 per read strobe; both together cancel
   always_comb begin
      w_level_nxt = r_level;
      if (w_grant && !r_rdreq) begin
         w_level_nxt = r_level + CW'(1);
      end else if (!w_grant && r_rdreq) begin
         w_level_nxt = r_level - CW'(1);
      end
   end

   // Write side: acks, FIFO write strobe/data, round-robin pointer, occupancy and soft clear
   always_ff @(posedge clock) begin
      if (sclr) begin
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
         r_wrreq <= 1'b0;
         r_fdata <= 8'h00;
         r_fsclr <= 1'b0;
         r_pri1  <= 1'b0;
         r_level <= '0;
      end else if (flush) begin
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
         r_wrreq <= 1'b0;
         r_fsclr <= 1'b1;
         r_level <= '0;
      end else begin
         r_ack0  <= w_gnt0;
         r_ack1  <= w_gnt1;
         r_wrreq <= w_grant;
         r_fsclr <= 1'b0;
         r_pri1  <= w_pri1_nxt;
         r_level <= w_level_nxt;
         if (w_grant) begin
            r_fdata <= w_gnt1 ? wr1_data : wr0_data;
         end
      end
   end

   // Read sequencer: strobe the FIFO, capture its registered output, then hold it for the consumer
   always_ff @(posedge clock) begin
      if (sclr) begin
         r_state    <= ST_IDLE;
         r_rdreq    <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= 8'h00;
      end else if (flush) begin
         r_state    <= ST_IDLE;
         r_rdreq    <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_level != '0) begin
                  r_state <= ST_ISSUE;
                  r_rdreq <= 1'b1;
               end
            end
            ST_ISSUE: begin
               r_rdreq <= 1'b0;
               r_state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               r_rd_data  <= fifo_q;
               r_rd_valid <= 1'b1;
               r_state    <= ST_HOLD;
            end
            ST_HOLD: begin
               // Going straight back to ISSUE keeps a streaming consumer at one byte per three cycles
               if (rd_ready) begin
                  r_rd_valid <= 1'b0;
                  if (r_level != '0) begin
                     r_state <= ST_ISSUE;
                     r_rdreq <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_rdreq <= 1'b0;
            end
         endcase
      end
   end

   // Sticky flag for any strobe that the FIFO flags would have refused
   always_ff @(posedge clock) begin
      if (sclr || flush) begin
         r_err <= 1'b0;
      end else begin
         r_err <= r_err || (r_wrreq && fifo_full) || (r_rdreq && fifo_empty);
      end
   end

`ifdef FIFO_CTRL_WATERMARK_EN
   // Watermark follows the occupancy register so both change on the same edge
   always_ff @(posedge clock) begin
      if (sclr || flush) begin
         r_af <= 1'b0;
      end else begin
         r_af <= (w_level_nxt >= CW'(AF_THRESH));
      end
   end
   assign almost_full = r_af;
`endif

   assign wr0_ack    = r_ack0;
   assign wr1_ack    = r_ack1;
   assign fifo_wrreq = r_wrreq;
   assign fifo_data  = r_fdata;
   assign fifo_rdreq = r_rdreq;
   assign fifo_sclr  = r_fsclr;
   assign rd_valid   = r_rd_valid;
   assign rd_data    = r_rd_data;
   assign err        = r_err;
   // Reported level saturates at the all-ones code when the FIFO is exactly full and DEPTH == 2**LW
   assign level      = (r_level > C_LVL_MAX) ? {LW{1'b1}} : r_level[LW-1:0];

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl with a 4-deep FIFO model
module tb_fifo_ctrl;

   localparam int DEPTH = 4;
   localparam int LW    = 3;

   logic          clock = 1'b0;
   logic          sclr, flush;
   logic          wr0_req, wr1_req, rd_ready;
   logic [7:0]    wr0_data, wr1_data;
   logic          wr0_ack, wr1_ack, rd_valid;
   logic [7:0]    rd_data, fifo_data, fifo_q;
   logic          fifo_wrreq, fifo_rdreq, fifo_sclr;
   logic          fifo_empty, fifo_full, err;
   logic [LW-1:0] level;
`ifdef FIFO_CTRL_WATERMARK_EN
   logic          almost_full;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] rx_q[$];
   logic       force_full = 1'b0;

   logic [7:0] m_mem [0:3];
   int         m_cnt, m_wp, m_rp;

   fifo_ctrl #(.DEPTH(DEPTH), .LW(LW), .AF_THRESH(3)) dut (
      .clock      (clock),
      .sclr       (sclr),
      .flush      (flush),
      .wr0_req    (wr0_req),
      .wr0_data   (wr0_data),
      .wr0_ack    (wr0_ack),
      .wr1_req    (wr1_req),
      .wr1_data   (wr1_data),
      .wr1_ack    (wr1_ack),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_ready   (rd_ready),
      .fifo_data  (fifo_data),
      .fifo_wrreq (fifo_wrreq),
      .fifo_rdreq (fifo_rdreq),
      .fifo_sclr  (fifo_sclr),
      .fifo_q     (fifo_q),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .level      (level),
`ifdef FIFO_CTRL_WATERMARK_EN
      .almost_full(almost_full),
`endif
      .err        (err)
   );

   always #5 clock = ~clock;

   // Normal-mode FIFO: q updates the cycle after rdreq
   always @(posedge clock) begin
      if (sclr || fifo_sclr) begin
         m_cnt  <= 0;
         m_wp   <= 0;
         m_rp   <= 0;
         fifo_q <= 8'h00;
      end else begin
         if (fifo_wrreq && m_cnt < DEPTH) begin
            m_mem[m_wp] <= fifo_data;
            m_wp <= (m_wp + 1) % DEPTH;
         end
         if (fifo_rdreq && m_cnt > 0) begin
            fifo_q <= m_mem[m_rp];
            m_rp <= (m_rp + 1) % DEPTH;
         end
         m_cnt <= m_cnt + ((fifo_wrreq && m_cnt < DEPTH) ? 1 : 0) - ((fifo_rdreq && m_cnt > 0) ? 1 : 0);
      end
   end
   assign fifo_empty = (m_cnt == 0);
   assign fifo_full  = force_full || (m_cnt == DEPTH);

   // Record every consumer handshake
   always @(negedge clock) begin
      if (rd_valid && rd_ready) rx_q.push_back(rd_data);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write0(input logic [7:0] d);
      int got;
      got = 0;
      wr0_data = d;
      wr0_req  = 1'b1;
      for (int i = 0; i < 30 && got == 0; i++) begin
         step();
         if (wr0_ack) got = 1;
      end
      chk("wr0_ack_seen", got, 1);
      wr0_req = 1'b0;
      step();
   endtask

   task automatic wait_rx(input int n);
      for (int i = 0; i < 200 && rx_q.size() < n; i++) step();
      chk("rx_count", rx_q.size(), n);
   endtask

   task automatic settle();
      for (int i = 0; i < 40 && (level != 0 || rd_valid || fifo_rdreq); i++) step();
      chk("settle_level", level, 0);
      chk("settle_err", err, 0);
   endtask

   initial begin
      logic [7:0] exp_d [4];
      int         exp_l [4];
      exp_d = '{8'h51, 8'h52, 8'h51, 8'h52};
      exp_l = '{1, 2, 2, 3};

      sclr = 1'b1; flush = 1'b0; rd_ready = 1'b0;
      wr0_req = 1'b0; wr1_req = 1'b0; wr0_data = 8'h00; wr1_data = 8'h00;

      // Reset
      for (int i = 0; i < 10; i++) step();
      chk("rst_flags", {rd_valid, wr0_ack, wr1_ack, fifo_wrreq, fifo_rdreq, fifo_sclr, err}, 0);
      chk("rst_level", level, 0);
      chk("rst_data", {rd_data, fifo_data}, 0);
      sclr = 1'b0;
      step();
      chk("post_rst_flags", {rd_valid, wr0_ack, wr1_ack, fifo_wrreq, fifo_rdreq, fifo_sclr, err}, 0);
      chk("post_rst_level", level, 0);

      // Single write and read latency
      wr0_data = 8'h01; wr0_req = 1'b1;
      step();
      chk("sw_ack0", wr0_ack, 1);
      chk("sw_ack1", wr1_ack, 0);
      chk("sw_wrreq", fifo_wrreq, 1);
      chk("sw_data", fifo_data, 8'h01);
      chk("sw_level", level, 1);
      wr0_req = 1'b0;
      step();
      chk("sw_ack0_1cyc", wr0_ack, 0);
      chk("sw_wrreq_1cyc", fifo_wrreq, 0);
      chk("sw_rdreq", fifo_rdreq, 1);
      step();
      chk("sw_rdreq_1cyc", fifo_rdreq, 0);
      chk("sw_level_dec", level, 0);
      chk("sw_valid_early", rd_valid, 0);
      step();
      chk("sw_valid", rd_valid, 1);
      chk("sw_rd_data", rd_data, 8'h01);
      rd_ready = 1'b1;
      step();
      chk("sw_valid_drop", rd_valid, 0);
      rd_ready = 1'b0;

      // Re-reset so the round-robin pointer favours requester 0 again
      sclr = 1'b1; step(); sclr = 1'b0; step();

      // Contention
      rx_q.delete();
      wr0_data = 8'h51; wr1_data = 8'h52;
      wr0_req = 1'b1; wr1_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("ct_ack0", wr0_ack, (i % 2 == 0) ? 1 : 0);
         chk("ct_ack1", wr1_ack, (i % 2 == 0) ? 0 : 1);
         chk("ct_wrreq", fifo_wrreq, 1);
         chk("ct_data", fifo_data, exp_d[i]);
         chk("ct_level", level, exp_l[i]);
      end
      chk("ct_hold_valid", rd_valid, 1);
      chk("ct_hold_data", rd_data, 8'h51);
      wr0_req = 1'b0; wr1_req = 1'b0; rd_ready = 1'b1;
      wait_rx(4);
      for (int i = 0; i < 4; i++) chk("ct_order", (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_d[i]);
      settle();

      // Drain ordering with a streaming consumer
      rx_q.delete();
      rd_ready = 1'b1;
      for (int d = 1; d <= 5; d++) write0(8'(d));
      wait_rx(5);
      for (int i = 0; i < 5; i++) chk("dr_order", (rx_q.size() > i) ? rx_q[i] : 8'hxx, i + 1);
      settle();

      // Full boundary: four bytes in the FIFO plus one parked in the output register
      rx_q.delete();
      rd_ready = 1'b0;
      for (int d = 1; d <= 5; d++) write0(8'(d));
      chk("fb_level_full", level, 4);
      chk("fb_valid", rd_valid, 1);
      wr0_data = 8'h06; wr0_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("fb_no_ack", wr0_ack, 0);
      end
      chk("fb_level_stall", level, 4);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      chk("fb_rdreq", fifo_rdreq, 1);
      step();
      chk("fb_ack_after_read", wr0_ack, 1);
      chk("fb_level_keep", level, 4);
      wr0_req = 1'b0;
      step();
      chk("fb_err", err, 0);
      rd_ready = 1'b1;
      wait_rx(6);
      for (int i = 0; i < 6; i++) chk("fb_order", (rx_q.size() > i) ? rx_q[i] : 8'hxx, i + 1);
      settle();

      // Flush mid-operation, also clearing a forced error
      rx_q.delete();
      rd_ready = 1'b0;
      write0(8'hAA);
      write0(8'hBB);
      force_full = 1'b1;
      write0(8'hCC);
      force_full = 1'b0;
      chk("fl_err_set", err, 1);
      for (int i = 0; i < 10 && !rd_valid; i++) step();
      chk("fl_valid_before", rd_valid, 1);
      chk("fl_data_before", rd_data, 8'hAA);
      chk("fl_level_before", level, 2);
      flush = 1'b1; wr1_data = 8'hDD; wr1_req = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_sclr", fifo_sclr, 1);
      chk("fl_valid", rd_valid, 0);
      chk("fl_level", level, 0);
      chk("fl_no_ack", wr1_ack, 0);
      chk("fl_no_strobes", {fifo_wrreq, fifo_rdreq}, 0);
      chk("fl_err_clr", err, 0);
      step();
      chk("fl_sclr_1cyc", fifo_sclr, 0);
      chk("fl_ack_after", wr1_ack, 1);
      chk("fl_data_after", fifo_data, 8'hDD);
      chk("fl_level_after", level, 1);
      wr1_req = 1'b0;
      rd_ready = 1'b1;
      wait_rx(1);
      settle();
      chk("fl_rx_count", rx_q.size(), 1);
      chk("fl_rx_data", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hDD);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
